f1_start_controller: RTL and testbench

Self-timed race-start controller for the F1 lights display. It contains its own enable-gated clock divider (tick every N+1 enabled cycles). It drives the 8-light bar through the fill sequence, holds all lights on for a pseudo-random number of ticks, then extinguishes them. It then measures the driver's reaction time in clock cycles and flags jump starts. It replaces the free-running light sequencer at the top level; `data_out` feeds the light bar directly.

---
 rtl/f1_start_controller.sv | 123 ++++++++++++
 tb/tb_f1_start_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_controller.sv
// f1_start_controller: self-timed F1 start-light sequencer with random hold and reaction timer
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   en         - global enable; freezes FSM and counters when low
//   N          - divider value, tick every N+1 enabled cycles
//   trigger    - start request, accepted only when idle
//   react      - driver button
//   data_out   - light bar
//   busy       - controller not idle
//   done       - one-cycle result strobe
//   jump_start - sticky jump-start flag, cleared by the next accepted trigger
//   reaction   - last reaction time in cycles (all ones on jump start or timeout)
module f1_start_controller #(
    parameter int WIDTH      = 16,
    parameter int D_WIDTH    = 8,
    parameter int LFSR_WIDTH = 7,
    parameter int RT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    N,
    input  logic                trigger,
    input  logic                react,
    output logic [D_WIDTH-1:0]  data_out,
    output logic                busy,
    output logic                done,
    output logic                jump_start,
    output logic [RT_WIDTH-1:0] reaction
);
    typedef enum logic [2:0] {IDLE, LIGHTS, DELAY, TIMING, RESULT} state_t;
    state_t                state, state_n;
    logic [WIDTH-1:0]      cnt, cnt_n;
    logic [LFSR_WIDTH-1:0] lfsr, dcnt, dcnt_n;
    logic [RT_WIDTH-1:0]   rcnt, rcnt_n, reaction_n;
    logic [D_WIDTH-1:0]    data_n, shifted;
    logic                  jump_n, tick, run;

    assign run     = state == LIGHTS || state == DELAY;
    assign tick    = en && run && cnt == '0;
    assign shifted = {data_out[D_WIDTH-2:0], 1'b1};
    assign busy    = state != IDLE;
    assign done    = state == RESULT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dcnt       <= '0;
            rcnt       <= '0;
            data_out   <= '0;
            jump_start <= 1'b0;
            reaction   <= '0;
            lfsr       <= LFSR_WIDTH'(1);
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dcnt       <= dcnt_n;
            rcnt       <= rcnt_n;
            data_out   <= data_n;
            jump_start <= jump_n;
            reaction   <= reaction_n;
            // free-running so the hold time depends on when the driver pressed start
            lfsr       <= {lfsr[LFSR_WIDTH-2:0], lfsr[LFSR_WIDTH-1] ^ lfsr[LFSR_WIDTH-2]};
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dcnt_n     = dcnt;
        rcnt_n     = rcnt;
        data_n     = data_out;
        jump_n     = jump_start;
        reaction_n = reaction;
        if (en && run) cnt_n = tick ? N : cnt - WIDTH'(1);
        case (state)
            IDLE: begin
                if (en && trigger) begin
                    state_n = LIGHTS;
                    cnt_n   = N;
                    data_n  = '0;
                    jump_n  = 1'b0;
                end
            end
            LIGHTS, DELAY: begin
                // a press before lights-out wins over any tick on the same edge
                if (en && react) begin
                    data_n     = '0;
                    jump_n     = 1'b1;
                    reaction_n = '1;
                    state_n    = RESULT;
                end else if (tick && state == LIGHTS) begin
                    data_n = shifted;
                    if (&shifted) begin
                        state_n = DELAY;
                        dcnt_n  = lfsr;
                    end
                end else if (tick) begin
                    dcnt_n = dcnt - LFSR_WIDTH'(1);
                    if (dcnt == LFSR_WIDTH'(1)) begin
                        data_n  = '0;
                        state_n = TIMING;
                        rcnt_n  = '0;
                    end
                end
            end
            TIMING: begin
                if (en && react) begin
                    reaction_n = rcnt;
                    state_n    = RESULT;
                end else if (en && &rcnt) begin
                    reaction_n = '1;
                    state_n    = RESULT;
                end else if (en) begin
                    rcnt_n = rcnt + RT_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_f1_start_controller.sv
// tb_f1_start_controller: checks the start controller against vectors, directed runs and a timeline model
module tb_f1_start_controller;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, trigger = 1'b0, react = 1'b0;
    logic [15:0] N = 16'd0;
    logic [7:0]  data_out;
    logic        busy, done, jump_start;
    logic [15:0] reaction;
    int          n_chk = 0, n_fail = 0;

    f1_start_controller dut (
        .clk(clk), .rst(rst), .en(en), .N(N), .trigger(trigger), .react(react),
        .data_out(data_out), .busy(busy), .done(done), .jump_start(jump_start), .reaction(reaction)
    );

    always #5 clk = ~clk;

    // Reference model: progress is the number of enabled edges k since the trigger was taken.
    // Lights = k/(N+1) capped at 8; lights go out at k=(8+d)(N+1); reaction = k beyond that.
    int          m_mode;
    int          m_k, m_d;
    logic [6:0]  m_lfsr;
    logic        m_jump;
    logic [15:0] m_reaction;

    function automatic int period();
        return int'(N) + 1;
    endfunction

    function automatic bit m_lit();
        return m_mode == 1 && (m_k < 8 * period() || m_k < (8 + m_d) * period());
    endfunction

    function automatic logic [7:0] m_data();
        int l;
        l = m_k / period();
        if (l > 8) l = 8;
        return m_lit() ? 8'((32'd1 << l) - 1) : 8'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_d = 0; m_lfsr = 7'h01; m_jump = 1'b0; m_reaction = 16'd0;
    endtask

    task automatic model_step();
        int         p, t;
        logic [6:0] pre;
        if (!rst) begin
            model_reset();
            return;
        end
        pre    = m_lfsr;
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        p      = period();
        if (m_mode == 2) m_mode = 0;
        else if (m_mode == 0) begin
            if (en && trigger) begin
                m_mode = 1; m_k = 0; m_d = 0; m_jump = 1'b0;
            end
        end else if (en) begin
            if (m_lit()) begin
                if (react) begin
                    m_jump = 1'b1; m_reaction = 16'hFFFF; m_mode = 2;
                end else begin
                    m_k++;
                    if (m_k == 8 * p) m_d = int'(pre);
                end
            end else begin
                t = m_k - (8 + m_d) * p;
                if (react) begin
                    m_reaction = 16'(t); m_mode = 2;
                end else if (t == 65535) begin
                    m_reaction = 16'hFFFF; m_mode = 2;
                end else m_k++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_data()));
        chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
        chk({tag, ".done"}, 32'(done), 32'(m_mode == 2));
        chk({tag, ".jump_start"}, 32'(jump_start), 32'(m_jump));
        chk({tag, ".reaction"}, 32'(reaction), 32'(m_reaction));
    endtask

    task automatic cycle(input logic e, input logic t, input logic r);
        en = e; trigger = t; react = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input logic e, input logic t, input logic r, input string tag);
        cycle(e, t, r);
        chk_model(tag);
    endtask

    typedef struct {
        logic        e, t, r;
        logic [7:0]  data;
        logic        busy, done, jump;
        logic [15:0] reaction;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int  n;
        logic e, t, r;
        vecs[0]  = '{1, 1, 0, 8'h00, 1, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 0, 8'h01, 1, 0, 0, 16'h0000};
        vecs[2]  = '{1, 0, 0, 8'h03, 1, 0, 0, 16'h0000};
        vecs[3]  = '{1, 0, 0, 8'h07, 1, 0, 0, 16'h0000};
        vecs[4]  = '{1, 0, 1, 8'h00, 1, 1, 1, 16'hFFFF};
        vecs[5]  = '{1, 0, 0, 8'h00, 0, 0, 1, 16'hFFFF};
        vecs[6]  = '{1, 1, 0, 8'h00, 1, 0, 0, 16'hFFFF};
        vecs[7]  = '{0, 0, 0, 8'h00, 1, 0, 0, 16'hFFFF};
        vecs[8]  = '{1, 0, 0, 8'h01, 1, 0, 0, 16'hFFFF};
        vecs[9]  = '{1, 0, 0, 8'h03, 1, 0, 0, 16'hFFFF};
        vecs[10] = '{0, 1, 1, 8'h03, 1, 0, 0, 16'hFFFF};
        vecs[11] = '{1, 0, 0, 8'h07, 1, 0, 0, 16'hFFFF};
        vecs[12] = '{1, 0, 1, 8'h00, 1, 1, 1, 16'hFFFF};
        vecs[13] = '{0, 0, 0, 8'h00, 0, 0, 1, 16'hFFFF};
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            N = 16'($urandom_range(0, 3));
            step(1'($urandom), 1'($urandom), 1'($urandom), "reset");
        end
        N = 16'd0;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'($urandom));
            chk("idle.busy", 32'(busy), 32'd0);
        end

        // vector table: jump start at 0x07, retrigger, en gating, RESULT with en low
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].e, vecs[i].t, vecs[i].r);
            chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].data));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d.jump_start", i), 32'(jump_start), 32'(vecs[i].jump));
            chk($sformatf("vec%0d.reaction", i), 32'(reaction), 32'(vecs[i].reaction));
        end

        // full run N=0, react in 5th cycle after lights-off
        step(1'b1, 1'b1, 1'b0, "run0.accept");
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, "run0.fill");
            chk("run0.light", 32'(data_out), 32'((32'd1 << i) - 1));
        end
        n = 0;
        while (data_out != 8'd0 && n < 200) begin
            step(1'b1, 1'b0, 1'b0, "run0.hold");
            n++;
        end
        chk("run0.delay_d", 32'(n), 32'(m_d));
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, "run0.timing");
        step(1'b1, 1'b0, 1'b1, "run0.react");
        chk("run0.reaction", 32'(reaction), 32'd4);
        chk("run0.done", 32'(done), 32'd1);
        chk("run0.jump_start", 32'(jump_start), 32'd0);
        step(1'b1, 1'b0, 1'b0, "run0.idle");
        chk("run0.done_off", 32'(done), 32'd0);

        // divider N=3
        N = 16'd3;
        step(1'b1, 1'b1, 1'b0, "div.accept");
        for (int l = 1; l <= 8; l++) begin
            n = 0;
            while (data_out != 8'((32'd1 << l) - 1) && n < 50) begin
                step(1'b1, 1'b0, 1'b0, "div.fill");
                n++;
            end
            chk($sformatf("div.light%0d_cycles", l), 32'(n), 32'd4);
        end
        step(1'b1, 1'b0, 1'b1, "div.jump");
        chk("div.jump_start", 32'(jump_start), 32'd1);
        step(1'b1, 1'b0, 1'b0, "div.idle");

        // en gating mid-LIGHTS with a trigger pulse while busy
        N = 16'd0;
        step(1'b1, 1'b1, 1'b0, "gate.accept");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "gate.fill");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i == 4, 1'b0, "gate.frozen");
            chk("gate.data_frozen", 32'(data_out), 32'h07);
        end
        step(1'b1, 1'b1, 1'b0, "gate.retrigger");
        chk("gate.resume", 32'(data_out), 32'h0F);
        for (int i = 5; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, "gate.fill2");
            chk("gate.light", 32'(data_out), 32'((32'd1 << i) - 1));
        end
        n = 0;
        while (data_out != 8'd0 && n < 200) begin
            step(1'b1, 1'b0, 1'b0, "gate.hold");
            n++;
        end
        chk("gate.delay_d", 32'(n), 32'(m_d));
        step(1'b1, 1'b0, 1'b1, "gate.react");
        chk("gate.reaction", 32'(reaction), 32'd0);
        step(1'b1, 1'b0, 1'b0, "gate.idle");

        // asynchronous reset mid-TIMING
        step(1'b1, 1'b1, 1'b0, "rst.accept");
        n = 0;
        while (!(m_mode == 1 && !m_lit()) && n < 200) begin
            step(1'b1, 1'b0, 1'b0, "rst.run");
            n++;
        end
        chk("rst.reached_timing", 32'(m_mode == 1 && !m_lit()), 32'd1);
        step(1'b1, 1'b0, 1'b0, "rst.timing");
        #2 rst = 1'b0;
        #1;
        chk("rst.async_data", 32'(data_out), 32'd0);
        chk("rst.async_busy", 32'(busy), 32'd0);
        chk("rst.async_reaction", 32'(reaction), 32'd0);
        model_reset();
        step(1'b1, 1'b0, 1'b1, "rst.held");
        chk("rst.no_done", 32'(done), 32'd0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, "rst.release");

        // random stimulus against the timeline model
        for (int i = 0; i < 4000; i++) begin
            if (m_mode == 0 && $urandom_range(0, 15) == 0) N = 16'($urandom_range(0, 3));
            e = $urandom_range(0, 7) != 0;
            t = $urandom_range(0, 3) == 0;
            r = m_lit() ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 5) == 0);
            step(e, t, r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
